// File: rtl/wb_pkg.sv
// Shared definitions for the writeback select block: source encodings,
// FSM state encodings, data widths and the default memory-wait timeout.
package wb_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned RA_W       = 5;
  localparam int unsigned PC_W       = 5;
  localparam int unsigned WB_TMO_DEF = 15;

  typedef enum logic [1:0] {
    WSEL_ALU  = 2'b00,
    WSEL_MEM  = 2'b01,
    WSEL_PC   = 2'b10,
    WSEL_NONE = 2'b11
  } wsel_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_WRITE    = 2'b10
  } state_e;

endpackage

// File: rtl/wb_mux.sv
// Combinational writeback source mux: ALU result, load data or zero-extended
// PC link value; the no-write encoding yields zero.
module wb_mux
  import wb_pkg::*;
(
  input  logic [1:0]      wsel,
  input  logic [XLEN-1:0] alu_res,
  input  logic [PC_W-1:0] pc_link,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] data_c
);

  always_comb begin
    data_c = '0;
    case (wsel)
      WSEL_ALU: data_c = alu_res;
      WSEL_MEM: data_c = mem_rdata;
      WSEL_PC:  data_c = XLEN'(pc_link);
      default:  data_c = '0;
    endcase
  end

endmodule

// File: rtl/wb_sel.sv
// Writeback select: accepts one request at a time, waits for load data with a
// timeout, and issues a single-cycle register-file write.
// Optional EX-stage bypass outputs are enabled with macro WB_SEL_FWD_EN.
module wb_sel
  import wb_pkg::*;
#(
  parameter int unsigned WB_TMO = WB_TMO_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      wsel,
  input  logic [XLEN-1:0] alu_res,
  input  logic [PC_W-1:0] pc_link,
  input  logic [RA_W-1:0] rd_addr,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            we,
  output logic [RA_W-1:0] wa,
  output logic [XLEN-1:0] wd,
  output logic            err
`ifdef WB_SEL_FWD_EN
  ,
  output logic            fwd_valid,
  output logic [RA_W-1:0] fwd_addr,
  output logic [XLEN-1:0] fwd_data
`endif
);

  localparam int unsigned CNT_W = (WB_TMO > 1) ? $clog2(WB_TMO) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WB_TMO - 1);

  state_e          state;
  logic [CNT_W-1:0] cnt;
  logic [RA_W-1:0] rd_q;
  logic [1:0]      mux_sel_c;
  logic [XLEN-1:0] mux_data_c;

  // While waiting on memory the mux must pick load data regardless of the bus.
  assign mux_sel_c = (state == ST_MEM_WAIT) ? WSEL_MEM : wsel;

  wb_mux u_mux (
    .wsel      (mux_sel_c),
    .alu_res   (alu_res),
    .pc_link   (pc_link),
    .mem_rdata (mem_rdata),
    .data_c    (mux_data_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      in_ready <= 1'b1;
      we       <= 1'b0;
      wa       <= '0;
      wd       <= '0;
      err      <= 1'b0;
      cnt      <= '0;
      rd_q     <= '0;
    end else begin
      we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            case (wsel)
              WSEL_ALU, WSEL_PC: begin
                wa       <= rd_addr;
                wd       <= mux_data_c;
                we       <= (rd_addr != '0);
                state    <= ST_WRITE;
                in_ready <= 1'b0;
              end
              WSEL_MEM: begin
                rd_q     <= rd_addr;
                cnt      <= '0;
                state    <= ST_MEM_WAIT;
                in_ready <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        // Load data arriving in the final allowed cycle still wins over timeout.
        ST_MEM_WAIT: begin
          if (mem_rvalid) begin
            wa    <= rd_q;
            wd    <= mux_data_c;
            we    <= (rd_q != '0);
            cnt   <= '0;
            state <= ST_WRITE;
          end else if (cnt == CNT_LAST) begin
            err      <= 1'b1;
            cnt      <= '0;
            state    <= ST_IDLE;
            in_ready <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_WRITE: begin
          state    <= ST_IDLE;
          in_ready <= 1'b1;
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef WB_SEL_FWD_EN
  // Bypass mirrors the registered write port.
  assign fwd_valid = we;
  assign fwd_addr  = wa;
  assign fwd_data  = wd;
`endif

endmodule

// File: tb/tb_wb_sel.sv
// Scoreboard bench for wb_sel: directed requests push expected writes, a
// negedge monitor pops and compares every register-file write.
module tb_wb_sel;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  wsel;
  logic [31:0] alu_res;
  logic [4:0]  pc_link;
  logic [4:0]  rd_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        err;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  wb_sel #(.WB_TMO(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .wsel       (wsel),
    .alu_res    (alu_res),
    .pc_link    (pc_link),
    .rd_addr    (rd_addr),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .we         (we),
    .wa         (wa),
    .wd         (wd),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every write the DUT presents must match the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=wa %h wd %h required=no write", wa, wd);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr", 32'(wa), 32'(e.a));
        chk("write_data", wd, e.d);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request and return 1 time unit after its accept edge.
  task automatic issue(input logic [1:0] s, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [4:0] pc);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) chk("ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    wsel     = s;
    rd_addr  = rd;
    alu_res  = alu;
    pc_link  = pc;
    tick();
    in_valid = 1'b0;
    wsel     = 2'b00;
    rd_addr  = 5'h1E;
    alu_res  = 32'hBAD0_BAD0;
    pc_link  = 5'h0A;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    wsel       = 2'b00;
    alu_res    = '0;
    pc_link    = '0;
    rd_addr    = '0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    tick();
    tick();
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_wa", 32'(wa), 32'd0);
    chk("rst_wd", wd, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_ready", 32'(in_ready), 32'd1);

    // ALU write, one-cycle latency, then idle with held address/data
    exp_q.push_back('{5'd5, 32'h0000_1234});
    issue(2'b00, 5'd5, 32'h0000_1234, 5'd0);
    chk("alu_we", 32'(we), 32'd1);
    chk("alu_busy", 32'(in_ready), 32'd0);
    tick();
    chk("alu_we_drop", 32'(we), 32'd0);
    chk("alu_ready", 32'(in_ready), 32'd1);
    chk("hold_wa", 32'(wa), 32'd5);
    chk("hold_wd", wd, 32'h0000_1234);

    // PC link zero-extended
    exp_q.push_back('{5'd31, 32'h0000_001F});
    issue(2'b10, 5'd31, 32'hFFFF_FFFF, 5'h1F);
    chk("pc_we", 32'(we), 32'd1);
    tick();

    // Load data valid while idle must be ignored
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1111_2222;
    tick();
    mem_rvalid = 1'b0;
    chk("idle_rvalid_we", 32'(we), 32'd0);

    // Load after 3 wait cycles
    exp_q.push_back('{5'd7, 32'hDEAD_BEEF});
    issue(2'b01, 5'd7, 32'h5555_5555, 5'd3);
    for (int i = 0; i < 3; i++) begin
      chk("mem_wait_busy", 32'(in_ready), 32'd0);
      tick();
    end
    chk("mem_wait_busy", 32'(in_ready), 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    chk("mem_we", 32'(we), 32'd1);
    tick();

    // rd 0 passes through WRITE without a write; wsel 11 is consumed
    issue(2'b00, 5'd0, 32'h7777_7777, 5'd0);
    chk("rd0_we", 32'(we), 32'd0);
    chk("rd0_busy", 32'(in_ready), 32'd0);
    tick();
    chk("rd0_ready", 32'(in_ready), 32'd1);
    issue(2'b11, 5'd4, 32'h8888_8888, 5'd4);
    chk("nowr_we", 32'(we), 32'd0);
    chk("nowr_ready", 32'(in_ready), 32'd1);
    tick();
    chk("nowr_ready2", 32'(in_ready), 32'd1);

    // Load data in the last allowed wait cycle beats the timeout
    exp_q.push_back('{5'd9, 32'hCAFE_F00D});
    issue(2'b01, 5'd9, 32'h0, 5'd0);
    repeat (14) tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_F00D;
    tick();
    mem_rvalid = 1'b0;
    chk("edge_we", 32'(we), 32'd1);
    chk("edge_err", 32'(err), 32'd0);
    tick();

    // Timeout after 15 wait cycles, then normal write with sticky err
    issue(2'b01, 5'd10, 32'h0, 5'd0);
    repeat (14) tick();
    chk("pre_tmo_err", 32'(err), 32'd0);
    chk("pre_tmo_busy", 32'(in_ready), 32'd0);
    tick();
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_ready", 32'(in_ready), 32'd1);
    chk("tmo_we", 32'(we), 32'd0);
    exp_q.push_back('{5'd3, 32'hA5A5_A5A5});
    issue(2'b00, 5'd3, 32'hA5A5_A5A5, 5'd0);
    chk("post_tmo_we", 32'(we), 32'd1);
    tick();
    chk("err_sticky", 32'(err), 32'd1);

    // Reset in the middle of a memory wait
    issue(2'b01, 5'd12, 32'h0, 5'd0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_we", 32'(we), 32'd0);
    chk("mid_rst_wa", 32'(wa), 32'd0);
    chk("mid_rst_wd", wd, 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    tick();
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h9999_9999;
    tick();
    mem_rvalid = 1'b0;
    chk("post_rst_we", 32'(we), 32'd0);
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    repeat (3) tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_sel.md
WB_SEL -- requirements
Module: wb_sel

Interface
REQ-001 SHALL: parameter WB_TMO, default 15, meaning memory-wait cycles allowed before timeout.
REQ-002 SHALL: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL: in_valid  input  1  writeback request present.
REQ-005 SHALL: in_ready  output  1  block can accept a request.
REQ-006 SHALL: wsel  input  2  source select: 00 ALU, 01 memory, 10 PC link, 11 no write.
REQ-007 SHALL: alu_res  input  32  ALU result.
REQ-008 SHALL: pc_link  input  5  PC value from offset adder, zero-extended to 32 bits when selected.
REQ-009 SHALL: rd_addr  input  5  destination register.
REQ-010 SHALL: mem_rvalid  input  1  load data valid.
REQ-011 SHALL: mem_rdata  input  32  load data.
REQ-012 SHALL: we  output  1  register-file write enable.
REQ-013 SHALL: wa  output  5  register-file write address.
REQ-014 SHALL: wd  output  32  register-file write data.
REQ-015 SHALL: err  output  1  sticky memory-timeout flag.

Function
REQ-016 SHALL: FSM states IDLE, MEM_WAIT, WRITE; in_ready=1 only in IDLE.
REQ-017 SHALL: accept on in_valid & in_ready; capture wsel, rd_addr, alu_res, pc_link in the accept cycle.
REQ-018 SHALL: wsel 00 -> wd=alu_res, next state WRITE; wsel 10 -> wd={27'b0,pc_link}, next state WRITE.
REQ-019 SHALL: wsel 01 -> next state MEM_WAIT; mem_rvalid sampled only in MEM_WAIT; on mem_rvalid capture mem_rdata into wd, go WRITE.
REQ-020 SHALL: wsel 11 -> request consumed, remain IDLE, no write.
REQ-021 SHALL: in WRITE, we=1 for exactly one cycle with wa=captured rd_addr, then IDLE; ALU/PC latency = 1 cycle after accept.
REQ-022 SHALL: rd_addr 0 -> FSM passes through WRITE but we stays 0.
REQ-023 SHALL: MEM_WAIT counter counts cycles spent in MEM_WAIT; after WB_TMO cycles without mem_rvalid, set err=1, return IDLE, no write.
REQ-024 SHALL: mem_rvalid in the same cycle the counter reaches WB_TMO takes priority -> normal write, err unchanged.
REQ-025 SHALL: err clears only on reset; further requests processed normally while err=1.
REQ-026 SHALL: wa/wd hold last captured value when we=0.

Reset
REQ-027 SHALL: rst asserted at any time -> state IDLE, we=0, wa=0, wd=0, err=0, counter=0, in_ready=1 one cycle after release edge, in-flight request discarded.

Configuration
REQ-028 SHALL: macro WB_SEL_FWD_EN defined -> extra outputs fwd_valid(1), fwd_addr(5), fwd_data(32) equal to we, wa, wd for EX-stage bypass, fwd_valid reset 0.
REQ-029 SHALL: WB_SEL_FWD_EN undefined -> those ports and logic absent; remaining behaviour identical.

Structure
REQ-030 SHALL: shared package wb_pkg holds wsel encodings, FSM state encodings, default WB_TMO.
REQ-031 SHALL: combinational source mux sub-module wb_mux (wsel, alu_res, pc_link, mem_rdata -> 32-bit data); FSM, counter and registers stay in wb_sel.

Verification
REQ-032 SHALL: wsel=00, alu_res=0x0000_1234, rd_addr=5 accepted cycle N -> cycle N+1 we=1, wa=5, wd=0x0000_1234; cycle N+2 we=0, in_ready=1.
REQ-033 SHALL: wsel=10, pc_link=5'h1F, rd_addr=31 -> wd=0x0000_001F, we=1 one cycle after accept.
REQ-034 SHALL: wsel=01, rd_addr=7, mem_rvalid after 3 wait cycles with 0xDEAD_BEEF -> in_ready=0 throughout, then we=1, wa=7, wd=0xDEAD_BEEF.
REQ-035 SHALL: wsel=01, no mem_rvalid for 15 cycles -> err=1, we never asserted, IDLE; next wsel=00 request writes normally, err stays 1.
REQ-036 SHALL: wsel=00, rd_addr=0 -> we=0; wsel=11 -> no write, in_ready stays 1.
REQ-037 SHALL: rst asserted mid-MEM_WAIT -> outputs zero immediately, later mem_rvalid ignored, no write.
